// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch front end.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 30;
  localparam int FETCH_DATA_W  = 32;
  localparam int FETCH_ENTRIES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic                    valid;
    logic [FETCH_ADDR_W-1:0] tag;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry tagged instruction buffer: hit / next-address lookup, victim choice, fill and flush.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FETCH_ADDR_W-1:0] pc,
  input  logic                    invalidate,
  input  logic                    wr_en,
  input  logic [FETCH_ADDR_W-1:0] wr_addr,
  input  logic [FETCH_DATA_W-1:0] wr_data,
  output logic                    hit,
  output logic [FETCH_DATA_W-1:0] hit_data,
  output logic                    next_hit
);

  fetch_entry_t entries [FETCH_ENTRIES];
  logic                     ptr;
  logic [FETCH_ENTRIES-1:0] hit_vec;
  logic [FETCH_ENTRIES-1:0] next_vec;
  logic [FETCH_ENTRIES-1:0] tag_vec;
  logic [FETCH_ADDR_W-1:0]  next_pc;
  logic                     victim;
  logic                     use_ptr;

  always_comb begin
    next_pc  = pc + FETCH_ADDR_W'(1);
    hit_data = '0;
    for (int i = 0; i < FETCH_ENTRIES; i++) begin
      hit_vec[i]  = entries[i].valid && (entries[i].tag == pc);
      next_vec[i] = entries[i].valid && (entries[i].tag == next_pc);
      tag_vec[i]  = entries[i].valid && (entries[i].tag == wr_addr);
      if (hit_vec[i]) hit_data = entries[i].data;
    end
    hit      = |hit_vec;
    next_hit = |next_vec;
  end

  // Refresh a same-tag entry first, then protect the entry the pipeline is using.
  always_comb begin
    use_ptr = 1'b0;
    victim  = 1'b0;
    if (tag_vec[0])             victim = 1'b0;
    else if (tag_vec[1])        victim = 1'b1;
    else if (hit_vec == 2'b01)  victim = 1'b1;
    else if (hit_vec == 2'b10)  victim = 1'b0;
    else begin
      victim  = ptr;
      use_ptr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FETCH_ENTRIES; i++) entries[i].valid <= 1'b0;
      ptr <= 1'b0;
    end else if (invalidate) begin
      for (int i = 0; i < FETCH_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (wr_en) begin
      entries[victim] <= '{valid: 1'b1, tag: wr_addr, data: wr_data};
      if (use_ptr) ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: miss / next-address prefetch FSM driving a req/ack memory bus.
// clk_enable is combinational on a buffer hit; fills become visible the cycle after mem_ack.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_W,
  parameter int DATA_WIDTH = FETCH_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  invalidate,
  output logic                  clk_enable,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic                  hit;
  logic                  next_hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  launch;
  logic                  fill;
  logic [ADDR_WIDTH-1:0] launch_addr;

  fetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .invalidate(invalidate),
    .wr_en     (fill),
    .wr_addr   (mem_addr),
    .wr_data   (mem_rdata),
    .hit       (hit),
    .hit_data  (hit_data),
    .next_hit  (next_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!hit || !next_hit) state_nxt = BUSY;
      BUSY:    if (mem_ack)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A demand miss outranks the prefetch of pc+1.
  always_comb begin
    launch      = (state == IDLE) && (!hit || !next_hit);
    launch_addr = hit ? (pc + ADDR_WIDTH'(1)) : pc;
    fill        = (state == BUSY) && mem_ack;
    clk_enable  = hit;
    instruction = hit ? hit_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (launch) begin
      mem_req  <= 1'b1;
      mem_addr <= launch_addr;
    end else if (fill) begin
      mem_req  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level buffer model.
module tb_fetch_unit;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          invalidate;
  logic          clk_enable;
  logic [DW-1:0] instruction;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .invalidate (invalidate),
    .clk_enable (clk_enable),
    .instruction(instruction),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Reference model: outstanding request plus two tagged slots.
  bit            m_busy;
  logic [AW-1:0] m_addr;
  bit            m_v [2];
  logic [AW-1:0] m_t [2];
  logic [DW-1:0] m_d [2];
  bit            m_ptr;

  int            lat;
  int            waited;
  bit            s_req;
  bit            last_ce;
  logic [AW-1:0] done_q [$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 32'h0000_0013;
    return DW'(a) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic int m_find(input logic [AW-1:0] a);
    for (int i = 0; i < 2; i++) if (m_v[i] && m_t[i] == a) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_addr = '0; m_v = '{0, 0}; m_ptr = 0;
    waited = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; invalidate = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive the memory responder, let the outputs settle, and compare with the model.
  task automatic settle();
    int h;
    s_req     = mem_req;
    mem_ack   = mem_req && (waited >= lat);
    mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    if (mem_ack) done_q.push_back(mem_addr);
    #1;
    h = m_find(pc);
    last_ce = clk_enable;
    chk("clk_enable", clk_enable, h >= 0);
    chk("instruction", instruction, (h >= 0) ? m_d[h] : 32'h0);
    chk("mem_req", mem_req, m_busy);
    chk("mem_addr", mem_addr, m_addr);
  endtask

  task automatic adv();
    int h, hn, v;
    bit use_ptr;
    logic [AW-1:0] nxt;
    @(posedge clk);
    if (s_req && !mem_ack) waited++; else waited = 0;
    h   = m_find(pc);
    nxt = pc + AW'(1);
    hn  = m_find(nxt);
    if (reset) begin
      model_reset();
    end else begin
      if (m_busy && mem_ack && !invalidate) begin
        v = m_find(m_addr);
        use_ptr = 0;
        if (v < 0) begin
          if (h >= 0) v = 1 - h;
          else begin v = int'(m_ptr); use_ptr = 1; end
        end
        m_v[v] = 1; m_t[v] = m_addr; m_d[v] = mem_word(m_addr);
        if (use_ptr) m_ptr = !m_ptr;
      end
      if (invalidate) m_v = '{0, 0};
      if (m_busy) begin
        if (mem_ack) m_busy = 0;
      end else if (h < 0) begin
        m_busy = 1; m_addr = pc;
      end else if (hn < 0) begin
        m_busy = 1; m_addr = nxt;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    pc = '0; lat = 0;

    // Cold miss on pc=0 with zero-wait memory.
    do_reset();
    done_q.delete();
    settle();
    chk("rst_ce", clk_enable, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_req", mem_req, 1'b0);
    adv();
    settle();
    chk("miss_req", mem_req, 1'b1);
    chk("miss_addr", mem_addr, 30'h0);
    adv();

    // Held pc: hit every cycle, a single prefetch of word 1.
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_ce", clk_enable, 1'b1);
      chk("hold_instr", instruction, 32'h0000_0013);
      adv();
    end
    chk("hold_nreq", done_q.size(), 2);
    chk("hold_pref", done_q[1], 30'h1);

    // Sequential stream 0 -> 1 -> 2.
    pc = 30'h1;
    settle();
    chk("seq_pc1_ce", clk_enable, 1'b1);
    adv();
    pc = 30'h2;
    step();
    settle();
    chk("seq_pc2_ce", clk_enable, 1'b1);
    adv();
    chk("seq_nreq", done_q.size(), 3);
    chk("seq_addr2", done_q[2], 30'h2);

    // Slow prefetch stays in flight while pc jumps away.
    do_reset();
    pc = 30'h1; lat = 0;
    step(); step(); step();
    lat = 3; pc = 30'h100;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("jump_hold_req", mem_req, 1'b1);
      chk("jump_hold_addr", mem_addr, 30'h2);
      chk("jump_hold_ce", clk_enable, 1'b0);
      adv();
    end
    settle();
    chk("jump_gap_req", mem_req, 1'b0);
    adv();
    n = 0;
    settle();
    while (!clk_enable && n < 12) begin
      if (mem_req) chk("jump_addr", mem_addr, 30'h100);
      adv();
      settle();
      n++;
    end
    chk("jump_ce", clk_enable, 1'b1);
    chk("jump_lat", n, 4);
    chk("jump_data", instruction, mem_word(30'h100));
    adv();

    // Flush coinciding with the fill of word 5.
    do_reset();
    pc = 30'h5; lat = 0;
    step();
    invalidate = 1'b1;
    settle();
    chk("inv_ack", mem_ack, 1'b1);
    adv();
    invalidate = 1'b0;
    settle();
    chk("inv_ce", clk_enable, 1'b0);
    chk("inv_req_gap", mem_req, 1'b0);
    adv();
    settle();
    chk("inv_req", mem_req, 1'b1);
    chk("inv_addr", mem_addr, 30'h5);
    adv();

    // Prefetch wraps past the top of the address space, then reset mid-request.
    do_reset();
    pc = '1; lat = 0;
    step(); step();
    settle();
    chk("wrap_ce", clk_enable, 1'b1);
    adv();
    lat = 2;
    settle();
    chk("wrap_req", mem_req, 1'b1);
    chk("wrap_addr", mem_addr, 30'h0);
    adv();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("busy_rst_req", mem_req, 1'b0);
    chk("busy_rst_addr", mem_addr, 30'h0);
    chk("busy_rst_ce", clk_enable, 1'b0);
    adv();

    // Randomized traffic.
    do_reset();
    pc = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!mem_req) lat = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        if (last_ce) pc = pc + AW'(1);
      end else if (r < 80) begin
        pc = pc;
      end else if (r < 88) begin
        pc = AW'($urandom_range(0, 15));
      end else if (r < 93) begin
        pc = '1 - AW'($urandom_range(0, 3));
      end else begin
        pc = pc - AW'(1);
      end
      invalidate = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    invalidate = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
